// File: rtl/segment_sequencer_pkg.sv
// Shared types and sizing for the segment sequencer and its point table.
package segment_sequencer_pkg;

   localparam int unsigned COORD_W    = 8;
   localparam int unsigned MAX_POINTS = 16;
   localparam int unsigned PT_ADDR_W  = 4;
   localparam int unsigned NUM_W      = 5;
   localparam int unsigned PT_W       = 2 * COORD_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      GAP    = 3'd3,
      FINISH = 3'd4
   } state_e;

   // Table entries are stored as {x,y}.
   function automatic logic [PT_W-1:0] pack_point(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
      return {x, y};
   endfunction

endpackage

// File: rtl/segment_sequencer_point_table.sv
// 16-entry {x,y} point store: one synchronous write port, two combinational read ports.
module point_table
   import segment_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [PT_ADDR_W-1:0] waddr_i,
   input  logic [PT_W-1:0]      wdata_i,
   input  logic [PT_ADDR_W-1:0] raddr_a_i,
   input  logic [PT_ADDR_W-1:0] raddr_b_i,
   output logic [PT_W-1:0]      rdata_a_c_o,
   output logic [PT_W-1:0]      rdata_b_c_o
);

   // Contents deliberately survive reset.
   logic [PT_W-1:0] mem_q [MAX_POINTS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_c_o = mem_q[raddr_a_i];
   assign rdata_b_c_o = mem_q[raddr_b_i];

endmodule

// File: rtl/segment_sequencer.sv
// Walks a table of points and hands consecutive pairs to a line-drawing stage, one segment at a time.
module segment_sequencer
   import segment_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_we,
   input  logic [PT_ADDR_W-1:0] load_addr,
   input  logic [COORD_W-1:0]   load_x,
   input  logic [COORD_W-1:0]   load_y,
   input  logic [NUM_W-1:0]     num_points,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 line_done,
   output logic                 line_enable,
   output logic [COORD_W-1:0]   startx,
   output logic [COORD_W-1:0]   starty,
   output logic [COORD_W-1:0]   endx,
   output logic [COORD_W-1:0]   endy,
   output logic [PT_ADDR_W-1:0] seg_idx,
   output logic                 busy,
   output logic                 all_done
);

   state_e               state_q, state_d;
   logic [PT_ADDR_W-1:0] seg_idx_q, seg_idx_d;
   logic [NUM_W-1:0]     num_q, num_d;
   logic [COORD_W-1:0]   sx_q, sx_d, sy_q, sy_d, ex_q, ex_d, ey_q, ey_d;
   logic                 le_q, le_d, busy_q, busy_d, done_q, done_d;
   logic [PT_W-1:0]      rd_a_c, rd_b_c;
   logic [NUM_W-1:0]     num_clamp_c;
   logic                 tbl_we_c;

   assign tbl_we_c    = load_we && !abort && (state_q == IDLE || state_q == FINISH);
   assign num_clamp_c = (num_points > NUM_W'(MAX_POINTS)) ? NUM_W'(MAX_POINTS) : num_points;

   point_table u_point_table (
      .clk         (clk),
      .we_i        (tbl_we_c),
      .waddr_i     (load_addr),
      .wdata_i     (pack_point(load_x, load_y)),
      .raddr_a_i   (seg_idx_q),
      .raddr_b_i   (seg_idx_q + PT_ADDR_W'(1)),
      .rdata_a_c_o (rd_a_c),
      .rdata_b_c_o (rd_b_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      seg_idx_d = seg_idx_q;
      num_d     = num_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      ex_d      = ex_q;
      ey_d      = ey_q;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, FINISH: begin
               if (start) begin
                  seg_idx_d = '0;
                  num_d     = num_clamp_c;
                  state_d   = (num_points >= NUM_W'(2)) ? LOAD : FINISH;
               end
            end
            LOAD: begin
               sx_d    = rd_a_c[PT_W-1:COORD_W];
               sy_d    = rd_a_c[COORD_W-1:0];
               ex_d    = rd_b_c[PT_W-1:COORD_W];
               ey_d    = rd_b_c[COORD_W-1:0];
               state_d = RUN;
            end
            RUN: begin
               if (line_done) begin
                  if (NUM_W'(seg_idx_q) == num_q - NUM_W'(2)) begin
                     state_d = FINISH;
                  end else begin
                     seg_idx_d = seg_idx_q + PT_ADDR_W'(1);
                     state_d   = GAP;
                  end
               end
            end
            GAP:     state_d = LOAD;
            default: state_d = IDLE;
         endcase
      end

      // Enable rises one cycle into RUN, once the endpoints have settled, and drops as RUN is left.
      le_d   = (state_q == RUN) && (state_d == RUN);
      busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == GAP);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         seg_idx_q <= '0;
         num_q     <= '0;
         sx_q      <= '0;
         sy_q      <= '0;
         ex_q      <= '0;
         ey_q      <= '0;
         le_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_idx_q <= seg_idx_d;
         num_q     <= num_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         ex_q      <= ex_d;
         ey_q      <= ey_d;
         le_q      <= le_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign line_enable = le_q;
   assign startx      = sx_q;
   assign starty      = sy_q;
   assign endx        = ex_q;
   assign endy        = ey_q;
   assign seg_idx     = seg_idx_q;
   assign busy        = busy_q;
   assign all_done    = done_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed self-checking bench for segment_sequencer.
module tb_segment_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_we;
   logic [3:0] load_addr;
   logic [7:0] load_x, load_y;
   logic [4:0] num_points;
   logic       start, abort, line_done;
   logic       line_enable;
   logic [7:0] startx, starty, endx, endy;
   logic [3:0] seg_idx;
   logic       busy, all_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] px [16];
   logic [7:0] py [16];

   segment_sequencer dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
      .load_x(load_x), .load_y(load_y), .num_points(num_points),
      .start(start), .abort(abort), .line_done(line_done),
      .line_enable(line_enable), .startx(startx), .starty(starty),
      .endx(endx), .endy(endy), .seg_idx(seg_idx), .busy(busy), .all_done(all_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_point(input logic [3:0] a, input logic [7:0] x, input logic [7:0] y);
      load_we = 1'b1; load_addr = a; load_x = x; load_y = y;
      tick();
      load_we = 1'b0;
   endtask

   // Start a run and advance to the first cycle with line_enable high (edge t+2).
   task automatic start_run(input logic [4:0] n);
      num_points = n; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({line_enable, busy, all_done, seg_idx} !== 7'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got le=%b busy=%b done=%b seg=%0d, want all 0", line_enable, busy, all_done, seg_idx);
      end
      checks++;
      if ({startx, starty, endx, endy} !== 32'd0) begin
         errors++;
         $display("FAIL reset_coords: got %h, want 0", {startx, starty, endx, endy});
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      load_point(4'd0, 8'd10, 8'd10);
      load_point(4'd1, 8'd20, 8'd10);
      load_point(4'd2, 8'd20, 8'd30);
      num_points = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({busy, line_enable} !== 2'b10) begin
         errors++;
         $display("FAIL basic_load: got busy=%b le=%b, want busy=1 le=0", busy, line_enable);
      end
      tick();
      checks++;
      if (line_enable !== 1'b0) begin
         errors++;
         $display("FAIL basic_le_t1: got %b, want 0", line_enable);
      end
      tick();
      checks++;
      if ({line_enable, seg_idx, startx, starty, endx, endy} !== {1'b1, 4'd0, 8'd10, 8'd10, 8'd20, 8'd10}) begin
         errors++;
         $display("FAIL basic_seg0: got le=%b seg=%0d (%0d,%0d)->(%0d,%0d), want le=1 seg=0 (10,10)->(20,10)",
                  line_enable, seg_idx, startx, starty, endx, endy);
      end
      // start while busy must not restart the run
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if ({line_enable, seg_idx, startx} !== {1'b1, 4'd0, 8'd10}) begin
         errors++;
         $display("FAIL basic_run_hold: got le=%b seg=%0d sx=%0d, want le=1 seg=0 sx=10", line_enable, seg_idx, startx);
      end
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      checks++;
      if ({line_enable, busy, seg_idx} !== {1'b0, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL basic_gap: got le=%b busy=%b seg=%0d, want le=0 busy=1 seg=1", line_enable, busy, seg_idx);
      end
      tick();
      tick();
      checks++;
      if ({line_enable, startx, starty, endx, endy} !== {1'b0, 8'd20, 8'd10, 8'd20, 8'd30}) begin
         errors++;
         $display("FAIL basic_seg1_load: got le=%b (%0d,%0d)->(%0d,%0d), want le=0 (20,10)->(20,30)",
                  line_enable, startx, starty, endx, endy);
      end
      tick();
      checks++;
      if (line_enable !== 1'b1) begin
         errors++;
         $display("FAIL basic_le_u3: got %b, want 1", line_enable);
      end
      line_done = 1'b1;
      tick();
      checks++;
      if ({all_done, busy, line_enable, seg_idx} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
         errors++;
         $display("FAIL basic_finish: got done=%b busy=%b le=%b seg=%0d, want done=1 busy=0 le=0 seg=1",
                  all_done, busy, line_enable, seg_idx);
      end
      // line_done outside RUN is ignored
      tick();
      line_done = 1'b0;
      checks++;
      if ({all_done, line_enable} !== 2'b10) begin
         errors++;
         $display("FAIL basic_done_ignored: got done=%b le=%b, want done=1 le=0", all_done, line_enable);
      end
   endtask

   task automatic test_write_ignored();
      start_run(5'd3);
      load_point(4'd0, 8'd99, 8'd99);
      load_point(4'd1, 8'd99, 8'd99);
      checks++;
      if ({startx, starty, endx, endy} !== {8'd10, 8'd10, 8'd20, 8'd10}) begin
         errors++;
         $display("FAIL wr_run_coords: got (%0d,%0d)->(%0d,%0d), want (10,10)->(20,10)", startx, starty, endx, endy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start_run(5'd3);
      checks++;
      if ({startx, starty, endx, endy} !== {8'd10, 8'd10, 8'd20, 8'd10}) begin
         errors++;
         $display("FAIL wr_table_kept: got (%0d,%0d)->(%0d,%0d), want (10,10)->(20,10)", startx, starty, endx, endy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      start_run(5'd3);
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      repeat (3) tick();
      checks++;
      if ({line_enable, seg_idx} !== {1'b1, 4'd1}) begin
         errors++;
         $display("FAIL abort_pre: got le=%b seg=%0d, want le=1 seg=1", line_enable, seg_idx);
      end
      // abort wins over a simultaneous line_done
      abort = 1'b1; line_done = 1'b1;
      tick();
      abort = 1'b0; line_done = 1'b0;
      checks++;
      if ({line_enable, busy, all_done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle: got le=%b busy=%b done=%b, want 0 0 0", line_enable, busy, all_done);
      end
      start_run(5'd3);
      checks++;
      if ({line_enable, seg_idx, startx, endx} !== {1'b1, 4'd0, 8'd10, 8'd20}) begin
         errors++;
         $display("FAIL abort_restart: got le=%b seg=%0d sx=%0d ex=%0d, want le=1 seg=0 sx=10 ex=20",
                  line_enable, seg_idx, startx, endx);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_short();
      for (int n = 0; n < 2; n++) begin
         num_points = 5'(n); start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if ({all_done, busy, line_enable} !== 3'b100) begin
            errors++;
            $display("FAIL short_n%0d: got done=%b busy=%b le=%b, want 1 0 0", n, all_done, busy, line_enable);
         end
         repeat (3) tick();
         checks++;
         if ({all_done, line_enable} !== 2'b10) begin
            errors++;
            $display("FAIL short_hold_n%0d: got done=%b le=%b, want done=1 le=0", n, all_done, line_enable);
         end
      end
   endtask

   task automatic test_midrun_reset();
      start_run(5'd3);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({line_enable, busy, seg_idx, startx} !== {1'b0, 1'b0, 4'd0, 8'd0}) begin
         errors++;
         $display("FAIL rst_async: got le=%b busy=%b seg=%0d sx=%0d, want 0 0 0 0", line_enable, busy, seg_idx, startx);
      end
      rst = 1'b1;
      tick();
      start_run(5'd3);
      checks++;
      if ({line_enable, startx, starty, endx, endy} !== {1'b1, 8'd10, 8'd10, 8'd20, 8'd10}) begin
         errors++;
         $display("FAIL rst_rerun: got le=%b (%0d,%0d)->(%0d,%0d), want le=1 (10,10)->(20,10)",
                  line_enable, startx, starty, endx, endy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         px[i] = 8'(i * 7 + 3);
         py[i] = 8'(200 - i * 5);
         load_point(4'(i), px[i], py[i]);
      end
      // 16 points, then 25 clamped to 16: both give 15 segments
      for (int pass = 0; pass < 2; pass++) begin
         start_run((pass == 0) ? 5'd16 : 5'd25);
         for (int k = 0; k < 15; k++) begin
            checks++;
            if ({line_enable, seg_idx, startx, starty, endx, endy} !==
                {1'b1, 4'(k), px[k], py[k], px[k+1], py[k+1]}) begin
               errors++;
               $display("FAIL full_p%0d_seg%0d: got le=%b seg=%0d (%0d,%0d)->(%0d,%0d), want le=1 seg=%0d (%0d,%0d)->(%0d,%0d)",
                        pass, k, line_enable, seg_idx, startx, starty, endx, endy,
                        k, px[k], py[k], px[k+1], py[k+1]);
            end
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
            if (k < 14) begin
               checks++;
               if (all_done !== 1'b0) begin
                  errors++;
                  $display("FAIL full_p%0d_early_done%0d: got done=%b, want 0", pass, k, all_done);
               end
               repeat (3) tick();
            end
         end
         checks++;
         if ({all_done, line_enable, seg_idx} !== {1'b1, 1'b0, 4'd14}) begin
            errors++;
            $display("FAIL full_p%0d_end: got done=%b le=%b seg=%0d, want done=1 le=0 seg=14",
                     pass, all_done, line_enable, seg_idx);
         end
      end
   endtask

   initial begin
      rst = 1'b0; load_we = 1'b0; load_addr = '0; load_x = '0; load_y = '0;
      num_points = '0; start = 1'b0; abort = 1'b0; line_done = 1'b0;
      test_reset();
      test_basic();
      test_write_ignored();
      test_abort();
      test_short();
      test_midrun_reset();
      test_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_sequencer.md
SEGMENT_SEQUENCER -- requirements
Module: segment_sequencer

Interface
REQ-001 SHALL expose: clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: load_we  input  1  point-table write strobe.
REQ-004 SHALL expose: load_addr  input  4  point-table write index, 0..15.
REQ-005 SHALL expose: load_x, load_y  input  8 each  point coordinates to write.
REQ-006 SHALL expose: num_points  input  5  number of valid points; legal range 0..16, sampled at start.
REQ-007 SHALL expose: start  input  1  single-cycle pulse that begins a run.
REQ-008 SHALL expose: abort  input  1  returns the block to IDLE from any state.
REQ-009 SHALL expose: line_done  input  1  done flag from the downstream line-drawing stage.
REQ-010 SHALL expose: line_enable  output  1  enable to the line stage; low clears that stage.
REQ-011 SHALL expose: startx, starty, endx, endy  output  8 each  current segment endpoints.
REQ-012 SHALL expose: seg_idx  output  4  index of the current segment.
REQ-013 SHALL expose: busy  output  1  high in LOAD, RUN and GAP.
REQ-014 SHALL expose: all_done  output  1  high in FINISH.

Function
REQ-015 Point table SHALL be 16 entries x 16 bits ({x,y}); a write SHALL occur on clk when load_we=1 and the state is IDLE or FINISH; writes in any other state SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN, GAP and FINISH; the state and all outputs SHALL be registered.
REQ-017 IDLE: on start=1 with num_points>=2, the block SHALL latch num_points, clear seg_idx and go to LOAD; with num_points<2 it SHALL go directly to FINISH (zero segments).
REQ-018 LOAD: the block SHALL register start{x,y}=table[seg_idx] and end{x,y}=table[seg_idx+1], then go to RUN; line_enable SHALL stay 0.
REQ-019 RUN: line_enable SHALL be 1 and endpoints SHALL be held stable; on line_done=1 the block SHALL go to FINISH if seg_idx==latched_num-2, otherwise to GAP with seg_idx incremented.
REQ-020 GAP: line_enable SHALL be 0 for exactly one cycle so the line stage resets; next state SHALL be LOAD.
REQ-021 FINISH: line_enable SHALL be 0 and all_done SHALL be 1 until a new start (handled as in IDLE) or abort.
REQ-022 Latency: a start sampled at edge t SHALL give line_enable=1 after edge t+2; line_done sampled at edge u SHALL give line_enable=1 for the next segment after edge u+3.
REQ-023 abort=1 SHALL take priority over start, line_done and load_we, forcing IDLE with line_enable=0 after the next edge.
REQ-024 start while busy SHALL be ignored.
REQ-025 line_done outside RUN SHALL be ignored.
REQ-026 Table contents SHALL be unchanged by start, abort and FINISH; seg_idx+1 arithmetic is 4-bit and SHALL never exceed 15, because latched_num is at most 16.
REQ-027 num_points>16 SHALL be clamped to 16 when latched.

Reset
REQ-028 On rst=0 the block SHALL asynchronously enter IDLE with line_enable=0, busy=0, all_done=0, seg_idx=0, start/end coordinates=0 and latched_num=0.
REQ-029 Point-table contents SHALL NOT be reset.
REQ-030 Reset asserted mid-run SHALL drop line_enable immediately, without waiting for a clock edge.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=0, LOAD=1, RUN=2, GAP=3, FINISH=4; 3 bits), COORD_W=8, MAX_POINTS=16 and PT_ADDR_W=4.
REQ-032 The point table SHALL be a sub-module point_table: one synchronous write port and two combinational read ports (seg_idx, seg_idx+1).

Verification
REQ-033 Load (10,10),(20,10),(20,30); num_points=3; start; line_done after 5 RUN cycles -> segment 0 shows (10,10)->(20,10), one GAP cycle, then segment 1 shows (20,10)->(20,30); the second line_done -> all_done=1.
REQ-034 num_points=1; start -> FINISH after the next edge, line_enable never 1.
REQ-035 num_points=16 with all points loaded -> exactly 15 segments, seg_idx runs 0..14, with no wrap.
REQ-036 abort during the RUN of segment 1 -> IDLE after the next edge, line_enable=0; a new start restarts at seg_idx=0.
REQ-037 rst=0 mid-RUN -> line_enable=0 before the next clk edge; after release the table is intact and a re-run produces the same endpoints.
REQ-038 load_we pulsed during RUN with data (99,99) -> table unchanged and endpoints unaffected.
